// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, controller states and loader byte-lane positions.
package mem_pkg;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 20;
  localparam int RAM_DEPTH = 1024;
  localparam int B0_LSB    = 0;
  localparam int B1_LSB    = 8;
  localparam int B2_LSB    = 16;
  localparam int B2_W      = DATA_W - B2_LSB;
  typedef enum logic [1:0] {IDLE, CPU_ACC, LOAD, LOAD_WR} state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs three loader bytes little-endian into one 20-bit word.
module word_assembler
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);
  logic [1:0]        r_idx;
  logic [DATA_W-1:0] r_word;
  assign word       = r_word;
  assign word_valid = byte_en && r_idx == 2'd2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (byte_en) begin
      r_idx <= word_valid ? 2'd0 : r_idx + 2'd1;
      if (r_idx == 2'd0) r_word[B0_LSB +: 8] <= byte_in;
      else if (r_idx == 2'd1) r_word[B1_LSB +: 8] <= byte_in;
      else r_word[B2_LSB +: B2_W] <= byte_in[B2_W-1:0];
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM controller arbitrating a CPU load/store port and a
// byte-stream boot loader; the loader wins whenever a session starts.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_words,
  input  logic              ld_byte_valid,
  output logic              ld_byte_ready,
  input  logic [7:0]        ld_byte,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_read
);
  state_t            r_state, w_next;
  logic              r_we, r_rsp_valid, r_done;
  logic [ADDR_W-1:0] r_addr, r_ptr;
  logic [DATA_W-1:0] r_wdata, r_rsp_data, w_word;
  logic [ADDR_W:0]   r_rem, r_count;
  logic              w_start, w_accept, w_word_valid, w_last;

  assign w_start       = r_state == IDLE && ld_start;
  assign cpu_req_ready = r_state == IDLE && !ld_start;
  assign w_accept      = cpu_req_valid && cpu_req_ready;
  assign w_last        = r_rem == (ADDR_W+1)'(1);
  assign ld_byte_ready = r_state == LOAD;
  assign ld_busy       = r_state == LOAD || r_state == LOAD_WR;
  assign ld_done       = r_done;
  assign ld_count      = r_count;
  assign cpu_rsp_valid = r_rsp_valid;
  assign cpu_rsp_data  = r_rsp_data;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_start),
    .byte_en   (ld_byte_ready && ld_byte_valid),
    .byte_in   (ld_byte),
    .word      (w_word),
    .word_valid(w_word_valid)
  );

  always_comb begin
    w_next    = r_state;
    ram_addr  = '0;
    ram_write = '0;
    ram_str   = 1'b0;
    ram_ld    = 1'b0;
    case (r_state)
      IDLE:    w_next = w_start ? (ld_words == '0 ? IDLE : LOAD) : (w_accept ? CPU_ACC : IDLE);
      CPU_ACC: begin
        ram_addr  = r_addr;
        ram_str   = r_we;
        ram_ld    = !r_we;
        ram_write = r_we ? r_wdata : '0;
        w_next    = IDLE;
      end
      LOAD:    w_next = w_word_valid ? LOAD_WR : LOAD;
      LOAD_WR: begin
        ram_addr  = r_ptr;
        ram_write = w_word;
        ram_str   = 1'b1;
        w_next    = w_last ? IDLE : LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_count     <= '0;
    end else begin
      r_rsp_valid <= r_state == CPU_ACC && !r_we;
      r_done      <= (w_start && ld_words == '0) || (r_state == LOAD_WR && w_last);
      if (r_state == CPU_ACC && !r_we) r_rsp_data <= ram_read;
      if (w_start) begin
        r_ptr   <= ADDR_W'(LOAD_BASE);
        r_rem   <= ld_words;
        r_count <= '0;
      end else if (w_accept) begin
        r_we    <= cpu_req_we;
        r_addr  <= cpu_req_addr;
        r_wdata <= cpu_req_wdata;
      end
      // pointer wraps naturally at the top of the RAM
      if (r_state == LOAD_WR) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
        r_rem   <= r_rem - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a word-level RAM model.
module tb_mem_ctrl;
  localparam int LOAD_BASE = 0;
  logic        clk = 0, rst = 1;
  logic        cpu_req_valid = 0, cpu_req_ready, cpu_req_we = 0;
  logic [9:0]  cpu_req_addr = 0;
  logic [19:0] cpu_req_wdata = 0;
  logic        cpu_rsp_valid;
  logic [19:0] cpu_rsp_data;
  logic        ld_start = 0, ld_byte_valid = 0, ld_byte_ready, ld_busy, ld_done;
  logic [10:0] ld_words = 0, ld_count;
  logic [7:0]  ld_byte = 0;
  logic [9:0]  ram_addr;
  logic [19:0] ram_write, ram_read;
  logic        ram_str, ram_ld;
  logic [19:0] mem [1024];
  logic [19:0] exp_mem [1024];
  int checks = 0, errors = 0;
  int str_cnt = 0, done_cnt = 0, rdy_viol = 0;
  logic [7:0] q[$];

  mem_ctrl #(.LOAD_BASE(LOAD_BASE)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .ld_start(ld_start), .ld_words(ld_words), .ld_byte_valid(ld_byte_valid),
    .ld_byte_ready(ld_byte_ready), .ld_byte(ld_byte), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_count(ld_count),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_str(ram_str), .ram_ld(ram_ld),
    .ram_read(ram_read)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_str) mem[ram_addr] <= ram_write;
  assign ram_read = ram_ld ? mem[ram_addr] : 20'h0;
  always @(negedge clk) begin
    if (ram_str) str_cnt++;
    if (ld_done) done_cnt++;
    if (ld_busy && cpu_req_ready) rdy_viol++;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [9:0] a, input logic [19:0] d);
    int n = 0;
    cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = d;
    while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
    chk("cpu_accept", cpu_req_ready, 1);
    @(negedge clk);
    cpu_req_valid = 0;
    chk("acc_addr", ram_addr, a);
    chk("acc_str", ram_str, we);
    chk("acc_ld", ram_ld, !we);
    if (we) begin chk("acc_wdata", ram_write, d); exp_mem[a] = d; end
    @(negedge clk);
    chk("rsp_valid", cpu_rsp_valid, !we);
    if (!we) chk("rsp_data", cpu_rsp_data, exp_mem[a]);
  endtask

  task automatic feed_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(3) == 0) @(negedge clk);
    ld_byte_valid = 1; ld_byte = b;
    while (!ld_byte_ready && n < 50) begin @(negedge clk); n++; end
    chk("byte_ready", ld_byte_ready, 1);
    @(negedge clk);
    ld_byte_valid = 0;
  endtask

  task automatic session(input int words, input bit gaps);
    int s0 = str_cnt, d0 = done_cnt, v0 = rdy_viol, n = 0;
    for (int w = 0; w < words; w++)
      exp_mem[(LOAD_BASE + w) % 1024] = {q[3*w+2][3:0], q[3*w+1], q[3*w]};
    ld_words = 11'(words); ld_start = 1;
    #1 chk("start_ready", cpu_req_ready, 0);
    @(negedge clk);
    ld_start = 0;
    if (words == 0) begin
      chk("zero_done", ld_done, 1);
      chk("zero_busy", ld_busy, 0);
      chk("zero_count", ld_count, 0);
      @(negedge clk); #1;
      chk("zero_str", str_cnt - s0, 0);
      chk("zero_pulses", done_cnt - d0, 1);
    end else begin
      chk("busy", ld_busy, 1);
      for (int i = 0; i < 3 * words; i++) feed_byte(q[i], gaps);
      while (!ld_done && n < 20) begin @(negedge clk); n++; end
      chk("done", ld_done, 1);
      chk("count", ld_count, words);
      chk("busy_end", ld_busy, 0);
      #1 chk("str_cycles", str_cnt - s0, words);
      @(negedge clk); #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("ready_in_session", rdy_viol - v0, 0);
    end
  endtask

  initial begin
    int bad;
    #1;
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_rsp_valid", cpu_rsp_valid, 0);
    chk("rst_rsp_data", cpu_rsp_data, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_byte_ready", ld_byte_ready, 0);
    chk("rst_ram", {ram_str, ram_ld, ram_addr, ram_write}, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    cpu_op(1, 10'd5, 20'hABCDE);
    cpu_op(0, 10'd5, 20'h0);
    chk("load5", cpu_rsp_data, 20'hABCDE);

    q = {8'h12, 8'h34, 8'hF5, 8'h78, 8'h56, 8'hA1};
    session(2, 1);
    chk("ram0", mem[0], 20'h53412);
    chk("ram1", mem[1], 20'h15678);

    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    cpu_req_valid = 1; cpu_req_we = 1; cpu_req_addr = 10'd3; cpu_req_wdata = 20'h3C3C3;
    session(4, 1);
    chk("late_store_str", ram_str, 1);
    chk("late_store_addr", ram_addr, 3);
    cpu_req_valid = 0;
    exp_mem[3] = 20'h3C3C3;
    @(negedge clk);
    chk("ram3_store", mem[3], 20'h3C3C3);
    chk("ram2_load", mem[2], exp_mem[2]);

    q.delete();
    for (int i = 0; i < 3072; i++) q.push_back(8'hFF);
    session(1024, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 20'hFFFFF) bad++;
    chk("fill_all", bad, 0);

    ld_words = 1; ld_start = 1;
    @(negedge clk);
    ld_start = 0;
    feed_byte(8'h11, 0);
    feed_byte(8'h22, 0);
    #2 rst = 1;
    #1;
    chk("abort_str", ram_str, 0);
    chk("abort_ready", cpu_req_ready, 1);
    chk("abort_busy", ld_busy, 0);
    chk("abort_byte_ready", ld_byte_ready, 0);
    @(negedge clk);
    rst = 0;
    chk("abort_ram0", mem[LOAD_BASE], 20'hFFFFF);
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'($urandom));
    session(3, 1);
    for (int i = 0; i < 3; i++) chk("resume_ram", mem[i], exp_mem[i]);

    session(0, 0);

    for (int i = 0; i < 40; i++) cpu_op(1'($urandom), 10'($urandom_range(15)), 20'($urandom));
    for (int i = 0; i < 16; i++) cpu_op(0, 10'(i), 20'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
